// File: rtl/chain_encoder_pkg.sv
// Shared types and constants for the chained transmit encoder.
// CHAIN_ENCODER_PARITY_EN widens each FIFO entry by a stored parity bit.
package chain_encoder_pkg;

    typedef enum logic [0:0] {
        S_SYNC = 1'b0,
        S_DATA = 1'b1
    } state_t;

    localparam logic [7:0] DEF_SYNC_WORD = 8'hA5;
    localparam logic [7:0] DEF_SEED      = 8'h00;

`ifdef CHAIN_ENCODER_PARITY_EN
    localparam int ENTRY_W = 10;
`else
    localparam int ENTRY_W = 9;
`endif

    // Entry layout: {[parity,] sync, byte}; parity is fixed at push time.
    function automatic logic [ENTRY_W-1:0] pack_entry(input logic sync, input logic [7:0] data);
`ifdef CHAIN_ENCODER_PARITY_EN
        return {^data, sync, data};
`else
        return {sync, data};
`endif
    endfunction

endpackage

// File: rtl/tx_fifo.sv
// First-word fall-through FIFO with synchronous active-low reset.
// Reset clears storage too, so the stale head reads as zero afterwards.
module tx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (ADDR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/chain_encoder_tx.sv
// Differential (running-XOR) byte encoder with periodic sync insertion into a FWFT FIFO.
// CHAIN_ENCODER_PARITY_EN adds out_parity, the even parity of the head byte.
//
// state  | meaning
// S_SYNC | waiting for FIFO space to emit the sync word and restart the chain
// S_DATA | accepting payload bytes for the current frame
module chain_encoder_tx
    import chain_encoder_pkg::*;
#(
    parameter int          DEPTH     = 4,
    parameter int          FRAME_LEN = 8,
    parameter logic [7:0]  SYNC_WORD = DEF_SYNC_WORD,
    parameter logic [7:0]  SEED      = DEF_SEED
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_sync
`ifdef CHAIN_ENCODER_PARITY_EN
    ,
    output logic       out_parity
`endif
);

    localparam int                CNT_W    = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   frame_cnt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [7:0]         chain;
    logic [7:0]         chain_nxt;
    logic [7:0]         enc;
    logic               push;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head;
    logic               fifo_full;
    logic               fifo_empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_SYNC;
            frame_cnt <= '0;
            chain     <= SEED;
        end else begin
            state     <= state_nxt;
            frame_cnt <= cnt_nxt;
            chain     <= chain_nxt;
        end
    end

    assign enc = in_data ^ chain;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = frame_cnt;
        chain_nxt  = chain;
        push       = 1'b0;
        push_entry = pack_entry(1'b0, enc);
        in_ready   = 1'b0;
        case (state)
            S_SYNC: begin
                if (!fifo_full) begin
                    push       = 1'b1;
                    push_entry = pack_entry(1'b1, SYNC_WORD);
                    chain_nxt  = SEED;
                    cnt_nxt    = '0;
                    state_nxt  = S_DATA;
                end
            end
            S_DATA: begin
                // Readiness is a function of FIFO space only, never of out_ready.
                in_ready = !fifo_full;
                if (in_valid && !fifo_full) begin
                    push      = 1'b1;
                    chain_nxt = enc;
                    if (frame_cnt == LAST_IDX) begin
                        state_nxt = S_SYNC;
                    end else begin
                        cnt_nxt = frame_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = S_SYNC;
        endcase
    end

    tx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (out_ready && !fifo_empty),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_data  = head[7:0];
    assign out_sync  = head[8];
`ifdef CHAIN_ENCODER_PARITY_EN
    assign out_parity = head[9];
`endif

endmodule

// File: tb/tb_chain_encoder_tx.sv
// Bench for chain_encoder_tx: queue-based frame/FIFO reference model plus directed scenarios.
// Build with CHAIN_ENCODER_PARITY_EN to also check out_parity.
module tb_chain_encoder_tx;

    localparam int         DEPTH     = 4;
    localparam int         FRAME_LEN = 8;
    localparam logic [7:0] SYNC      = 8'hA5;
    localparam logic [7:0] SEEDV     = 8'h00;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_sync;
`ifdef CHAIN_ENCODER_PARITY_EN
    logic       out_parity;
`endif

    chain_encoder_tx #(
        .DEPTH     (DEPTH),
        .FRAME_LEN (FRAME_LEN),
        .SYNC_WORD (SYNC),
        .SEED      (SEEDV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sync  (out_sync)
`ifdef CHAIN_ENCODER_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: entries waiting in the FIFO as {sync, byte}.
    logic [8:0] mq[$];
    logic [8:0] popped[$];
    bit         sync_pending;
    int         frame_pos;
    logic [7:0] frame_xor;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        sync_pending = 1'b1;
        frame_pos    = 0;
        frame_xor    = 8'h00;
    endtask

    // Check outputs for the current cycle, advance the model over the next edge.
    task automatic cycle(output bit acc);
        int         pre;
        logic [7:0] enc;
        chk("in_ready", in_ready, (!sync_pending && mq.size() < DEPTH));
        chk("out_valid", out_valid, (mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_data", out_data, mq[0][7:0]);
            chk("out_sync", out_sync, mq[0][8]);
`ifdef CHAIN_ENCODER_PARITY_EN
            chk("out_parity", out_parity, ^mq[0][7:0]);
`endif
        end
        if (out_valid && out_ready) popped.push_back({out_sync, out_data});
        pre = mq.size();
        acc = 1'b0;
        if (pre != 0 && out_ready) void'(mq.pop_front());
        if (sync_pending) begin
            if (pre < DEPTH) begin
                mq.push_back({1'b1, SYNC});
                sync_pending = 1'b0;
                frame_pos    = 0;
                frame_xor    = 8'h00;
            end
        end else if (in_valid && pre < DEPTH) begin
            // Encoded byte = SEED xor every payload byte of the frame so far, including this one.
            frame_xor = frame_xor ^ in_data;
            enc       = SEEDV ^ frame_xor;
            mq.push_back({1'b0, enc});
            acc = 1'b1;
            frame_pos++;
            if (frame_pos == FRAME_LEN) sync_pending = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_in_ready", in_ready, 1'b0);
            chk("rst_out_data", out_data, 8'h00);
            chk("rst_out_sync", out_sync, 1'b0);
`ifdef CHAIN_ENCODER_PARITY_EN
            chk("rst_out_parity", out_parity, 1'b0);
`endif
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
    endtask

    // Offer one byte until accepted, bounded.
    task automatic send(input logic [7:0] b);
        bit acc;
        int tries;
        in_valid = 1'b1;
        in_data  = b;
        acc      = 1'b0;
        tries    = 0;
        while (!acc && tries < 40) begin
            cycle(acc);
            tries++;
        end
        chk("send_timeout", acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(acc);
    endtask

    logic [8:0] exp3 [10];
    bit         acc_b;
    int         n_acc;
    int         tries;
    logic [7:0] pend;

    initial begin
        exp3 = '{9'h001, 9'h000, 9'h001, 9'h000, 9'h001, 9'h000, 9'h001, 9'h000, 9'h1A5, 9'h001};
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b1;
        model_reset();

        // 1: reset and sync emission
        do_reset(5);
        idle(1);
        chk("tp1_sync_data", out_data, 8'hA5);
        chk("tp1_sync_flag", out_sync, 1'b1);
        chk("tp1_ready", in_ready, 1'b1);
        idle(1);

        // 2: two chained bytes
        in_valid = 1'b1; in_data = 8'h6C;
        cycle(acc_b);
        in_data = 8'h84;
        chk("tp2_first", out_data, 8'h6C);
        cycle(acc_b);
        in_valid = 1'b0;
        chk("tp2_second", out_data, 8'hE8);
        chk("tp2_second_sync", out_sync, 1'b0);
        idle(1);

        // finish the frame so the next test starts on a frame boundary
        for (int i = 0; i < 6; i++) send(8'($urandom));
        idle(4);

        // 3: nine bytes of 01 across a frame boundary
        popped.delete();
        for (int i = 0; i < 9; i++) send(8'h01);
        idle(4);
        chk("tp3_len", popped.size(), 10);
        for (int i = 0; i < 10; i++)
            chk("tp3_seq", (i < popped.size()) ? popped[i] : 9'h1FF, exp3[i]);

        // 4: backpressure fills the FIFO
        out_ready = 1'b0;
        n_acc = 0;
        pend  = 8'($urandom);
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = pend;
            cycle(acc_b);
            if (acc_b) begin n_acc++; pend = 8'($urandom); end
        end
        chk("tp4_accepted", n_acc, 4);
        chk("tp4_ready_low", in_ready, 1'b0);
        popped.delete();
        out_ready = 1'b1;
        tries = 0;
        while (n_acc < 6 && tries < 40) begin
            in_data = pend;
            cycle(acc_b);
            if (acc_b) begin n_acc++; pend = 8'($urandom); end
            tries++;
        end
        in_valid = 1'b0;
        chk("tp4_timeout", n_acc, 6);
        idle(6);
        chk("tp4_drained", popped.size(), 6);

        // 5: reset flushes a partly filled FIFO mid-frame
        send(8'($urandom));
        idle(4);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(8'($urandom));
        chk("tp5_queued", out_valid, 1'b1);
        do_reset(2);
        out_ready = 1'b1;
        idle(1);
        chk("tp5_first_sync", out_data, 8'hA5);
        chk("tp5_first_flag", out_sync, 1'b1);
`ifdef CHAIN_ENCODER_PARITY_EN
        chk("tp6_sync_parity", out_parity, 1'b0);
`endif
        idle(1);
        in_valid = 1'b1; in_data = 8'h07;
        cycle(acc_b);
        in_valid = 1'b0;
        chk("tp5_chain_restart", out_data, 8'h07);
        chk("tp5_chain_flag", out_sync, 1'b0);
`ifdef CHAIN_ENCODER_PARITY_EN
        chk("tp6_data_parity", out_parity, 1'b1);
`endif
        idle(1);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = 8'($urandom);
            cycle(acc_b);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(12);
        chk("final_empty", out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
